// File: rtl/test_counter.sv
// Pushbutton-driven TDC stimulus: sw2 fires a teststart/teststop pair, sw1 steps the delay shown on a 7-seg digit.
// Optional TESTCOUNTER_AUTO_REPEAT_EN: sw2 toggles a run flag that fires shots back-to-back.
//
// state | meaning
// IDLE  | waiting for an accepted sw2 press
// START | teststart high for PULSE_CYCLES
// WAIT  | remainder of start-to-stop delay
// STOP  | teststop high for PULSE_CYCLES
// GAP   | idle spacing between auto-repeated shots
module test_counter #(
  parameter int PULSE_CYCLES   = 2,
  parameter int BASE_DELAY     = 4,
  parameter int DELAY_STEP     = 1,
  parameter int LOCKOUT_CYCLES = 1024,
  parameter int REPEAT_GAP     = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw1,
  input  logic       sw2,
  output logic       teststart,
  output logic       teststop,
  output logic [6:0] led
);

  localparam int MAX_D = BASE_DELAY + 15 * DELAY_STEP;
  localparam int CW    = $clog2(LOCKOUT_CYCLES + MAX_D + REPEAT_GAP + PULSE_CYCLES + 2);

  typedef enum logic [2:0] {IDLE, START, WAIT, STOP, GAP} state_t;

  logic [1:0]    sync1, sync2;
  logic          prev1, prev2;
  logic          fall1, fall2;
  logic          accept1, accept2;
  logic          press1, press2;
  logic [CW-1:0] lock1, lock2;
  logic [3:0]    setting;
  logic          fire;

  state_t        state, state_n;
  logic [CW-1:0] dly_cnt, dly_n;
  logic [CW-1:0] pls_cnt, pls_n;
  logic          start_n, stop_n;
  logic [CW-1:0] dly_load;

  // Synchronisers preset high so reset never looks like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
      prev1 <= 1'b1;
      prev2 <= 1'b1;
    end else begin
      sync1 <= {sync1[0], sw1};
      sync2 <= {sync2[0], sw2};
      prev1 <= sync1[1];
      prev2 <= sync2[1];
    end
  end

  assign fall1   = prev1 & ~sync1[1];
  assign fall2   = prev2 & ~sync2[1];
  assign accept1 = fall1 && (lock1 == '0);
  assign accept2 = fall2 && (lock2 == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock1  <= '0;
      lock2  <= '0;
      press1 <= 1'b0;
      press2 <= 1'b0;
    end else begin
      press1 <= accept1;
      press2 <= accept2;
      if (accept1)
        lock1 <= CW'(LOCKOUT_CYCLES);
      else if (lock1 != '0)
        lock1 <= lock1 - CW'(1);
      if (accept2)
        lock2 <= CW'(LOCKOUT_CYCLES);
      else if (lock2 != '0)
        lock2 <= lock2 - CW'(1);
    end
  end

  function automatic logic [6:0] hex_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      setting <= 4'd0;
      led     <= 7'b1000000;
    end else begin
      if (press1)
        setting <= setting + 4'd1;
      led <= hex_seg(setting);
    end
  end

  // Loaded with D-1 so teststop rises exactly D cycles after teststart.
  assign dly_load = CW'(BASE_DELAY - 1 + int'(setting) * DELAY_STEP);

`ifdef TESTCOUNTER_AUTO_REPEAT_EN
  logic run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      run <= 1'b0;
    else if (press2)
      run <= ~run;
  end

  assign fire = press2 && !run;
`else
  assign fire = press2;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      dly_cnt   <= '0;
      pls_cnt   <= '0;
      teststart <= 1'b0;
      teststop  <= 1'b0;
    end else begin
      state     <= state_n;
      dly_cnt   <= dly_n;
      pls_cnt   <= pls_n;
      teststart <= start_n;
      teststop  <= stop_n;
    end
  end

  always_comb begin
    state_n = state;
    dly_n   = dly_cnt;
    pls_n   = pls_cnt;
    start_n = 1'b0;
    stop_n  = 1'b0;
    case (state)
      IDLE: begin
        if (fire) begin
          state_n = START;
          start_n = 1'b1;
          dly_n   = dly_load;
          pls_n   = CW'(PULSE_CYCLES - 1);
        end
      end
      START: begin
        dly_n = dly_cnt - CW'(1);
        if (pls_cnt == '0) begin
          state_n = WAIT;
        end else begin
          start_n = 1'b1;
          pls_n   = pls_cnt - CW'(1);
        end
      end
      WAIT: begin
        if (dly_cnt == '0) begin
          state_n = STOP;
          stop_n  = 1'b1;
          pls_n   = CW'(PULSE_CYCLES - 1);
        end else begin
          dly_n = dly_cnt - CW'(1);
        end
      end
      STOP: begin
        if (pls_cnt == '0) begin
          state_n = IDLE;
`ifdef TESTCOUNTER_AUTO_REPEAT_EN
          if (run) begin
            state_n = GAP;
            pls_n   = CW'(REPEAT_GAP - 1);
          end
`endif
        end else begin
          stop_n = 1'b1;
          pls_n  = pls_cnt - CW'(1);
        end
      end
      GAP: begin
`ifdef TESTCOUNTER_AUTO_REPEAT_EN
        if (!run) begin
          state_n = IDLE;
        end else if (pls_cnt == '0) begin
          state_n = START;
          start_n = 1'b1;
          dly_n   = dly_load;
          pls_n   = CW'(PULSE_CYCLES - 1);
        end else begin
          pls_n = pls_cnt - CW'(1);
        end
`else
        state_n = IDLE;
`endif
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_test_counter.sv
// Self-checking bench for test_counter (default build): randomized button timing and setting steps
// checked against a cycle-level model of shot timing, setting arithmetic and the hex digit table.
module tb_test_counter;
  localparam int PULSE = 2;
  localparam int BASE  = 4;
  localparam int STEP  = 1;
  localparam int SETTLE = 1100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sw1 = 1'b1;
  logic       sw2 = 1'b1;
  logic       teststart, teststop;
  logic [6:0] led;

  test_counter dut (
    .clk(clk), .rst(rst), .sw1(sw1), .sw2(sw2),
    .teststart(teststart), .teststop(teststop), .led(led)
  );

  always #20 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;
  int setting_m = 0;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  int start_rise[$];
  int stop_rise[$];
  int start_w[$];
  int stop_w[$];
  int overlaps = 0;
  logic pst = 1'b0, psp = 1'b0;
  int last_s = 0, last_p = 0;

  // Edge-event recorder: cycle numbers of pulse rises and pulse widths.
  always @(negedge clk) begin
    if (teststart && !pst) begin start_rise.push_back(cyc); last_s = cyc; end
    if (!teststart && pst) start_w.push_back(cyc - last_s);
    if (teststop && !psp) begin stop_rise.push_back(cyc); last_p = cyc; end
    if (!teststop && psp) stop_w.push_back(cyc - last_p);
    if (teststart && teststop) overlaps++;
    pst = teststart;
    psp = teststop;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_q();
    start_rise.delete();
    stop_rise.delete();
    start_w.delete();
    stop_w.delete();
    overlaps = 0;
  endtask

  task automatic step_setting();
    @(negedge clk);
    sw1 = 1'b0;
    repeat ($urandom_range(2, 5)) @(negedge clk);
    sw1 = 1'b1;
    setting_m = (setting_m + 1) % 16;
    repeat (SETTLE) @(negedge clk);
    check("led_after_step", int'(led), int'(seg_tab[setting_m]));
  endtask

  // One shot; optionally an sw1 press right after sw2, or a second sw2 press inside lockout.
  task automatic fire(input bit sw1_mid, input bit double_press);
    int n, exp_d, h;
    clear_q();
    exp_d = BASE + setting_m * STEP;
    h = $urandom_range(2, 5);
    @(negedge clk);
    n = cyc;
    sw2 = 1'b0;
    @(negedge clk);
    if (sw1_mid) sw1 = 1'b0;
    repeat (h) @(negedge clk);
    sw2 = 1'b1;
    sw1 = 1'b1;
    if (sw1_mid) setting_m = (setting_m + 1) % 16;
    if (double_press) begin
      repeat ($urandom_range(4, 8)) @(negedge clk);
      sw2 = 1'b0;
      repeat ($urandom_range(2, 4)) @(negedge clk);
      sw2 = 1'b1;
    end
    repeat (SETTLE) @(negedge clk);
    check("start_count", start_rise.size(), 1);
    check("stop_count", stop_rise.size(), 1);
    check("start_latency", (start_rise.size() > 0) ? start_rise[0] - n : -1, 4);
    check("start_to_stop", (start_rise.size() > 0 && stop_rise.size() > 0) ?
          stop_rise[0] - start_rise[0] : -1, exp_d);
    check("start_width", (start_w.size() > 0) ? start_w[0] : -1, PULSE);
    check("stop_width", (stop_w.size() > 0) ? stop_w[0] : -1, PULSE);
    check("overlap", overlaps, 0);
    check("led_after_shot", int'(led), int'(seg_tab[setting_m]));
  endtask

  initial begin
    int k;
    repeat (3) @(negedge clk);
    check("rst_start", int'(teststart), 0);
    check("rst_stop", int'(teststop), 0);
    check("rst_led", int'(led), int'(seg_tab[0]));
    rst = 1'b0;
    repeat (5) @(negedge clk);

    fire(1'b0, 1'b0);

    repeat (3) step_setting();
    check("led_three", int'(led), 7'b0110000);
    fire(1'b0, 1'b0);

    k = $urandom_range(1, 5);
    repeat (k) step_setting();
    fire(1'b1, 1'b0);
    fire(1'b0, 1'b1);

    k = setting_m;
    repeat (16) step_setting();
    check("wrap_setting_led", int'(led), int'(seg_tab[k]));
    fire(1'b0, 1'b0);

    if (setting_m == 0) step_setting();
    clear_q();
    @(negedge clk);
    sw2 = 1'b0;
    repeat (3) @(negedge clk);
    sw2 = 1'b1;
    k = 0;
    while (!teststart && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("midshot_started", int'(teststart), 1);
    #5 rst = 1'b1;
    #1;
    check("midshot_rst_start", int'(teststart), 0);
    check("midshot_rst_stop", int'(teststop), 0);
    check("midshot_rst_led", int'(led), int'(seg_tab[0]));
    setting_m = 0;
    @(negedge clk);
    rst = 1'b0;
    clear_q();
    repeat (SETTLE) @(negedge clk);
    check("post_rst_no_pulse", start_rise.size() + stop_rise.size(), 0);
    fire(1'b0, 1'b0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
